// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline multiply/divide unit.
//   muldiv_op_e     : ctrl encodings presented to b_muldiv
//   muldiv_state_e  : b_muldiv sequencer states
//   MULDIV_ITER     : radix-2 iterations per multiply/divide
//   abs32()         : two's-complement magnitude, optionally signed
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_NOP0  = 3'b110,
      OP_NOP1  = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_e;

   localparam int MULDIV_ITER = 32;
   localparam int MULDIV_CNT_W = $clog2(MULDIV_ITER);

   // Magnitude of a 32-bit value. 0x80000000 maps to itself, which is the
   // correct unsigned magnitude of -2^31.
   function automatic logic [31:0] abs32(input logic [31:0] val, input logic is_signed);
      abs32 = (is_signed && val[31]) ? (~val + 32'd1) : val;
   endfunction

endpackage

// File: rtl/b_muldiv_step.sv
// -----------------------------------------------------------------------------
// b_muldiv_step
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   i_op_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   i_acc     : 64-bit working register
//                 multiply: {partial product high, remaining multiplier bits}
//                 divide  : {partial remainder, dividend bits / quotient bits}
//   i_opnd    : multiplicand (multiply) or divisor (divide) magnitude
//   o_acc     : working register after this iteration
// -----------------------------------------------------------------------------
module b_muldiv_step
   import mips_pkg::*;
(
   input  logic        i_op_div,
   input  logic [63:0] i_acc,
   input  logic [31:0] i_opnd,
   output logic [63:0] o_acc
);

   logic [32:0] mul_sum;
   logic [32:0] div_part;
   logic        div_fits;
   logic [31:0] div_diff;

   // Multiply: add the multiplicand into the high half when the current
   // multiplier bit (LSB) is set, then shift the whole accumulator right.
   assign mul_sum = {1'b0, i_acc[63:32]} + {1'b0, i_opnd};

   // Divide: shift the next dividend bit into the partial remainder (33 bits
   // wide) and try to subtract. When it fits the result is below the divisor,
   // so a 32-bit modular difference holds it exactly.
   assign div_part = {i_acc[63:32], i_acc[31]};
   assign div_fits = (div_part >= {1'b0, i_opnd});
   assign div_diff = div_part[31:0] - i_opnd;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch can never be inferred.
      o_acc = i_acc;
      if (i_op_div) begin
         if (div_fits) begin
            o_acc = {div_diff, i_acc[30:0], 1'b1};
         end else begin
            o_acc = {div_part[31:0], i_acc[30:0], 1'b0};
         end
      end else begin
         if (i_acc[0]) begin
            o_acc = {mul_sum, i_acc[31:1]};
         end else begin
            o_acc = {1'b0, i_acc[63:32], i_acc[31:1]};
         end
      end
   end

endmodule

// File: rtl/b_muldiv.sv
// -----------------------------------------------------------------------------
// b_muldiv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles (32 iterations + sign fix-up);
// MTHI/MTLO write on the start edge.
//   i_b_muldiv_clk        : clock, rising edge
//   i_b_muldiv_rst_n      : asynchronous active-low reset
//   i_b_muldiv_start      : request, sampled only while idle
//   i_b_muldiv_ctrl       : operation (see mips_pkg::muldiv_op_e)
//   i_b_muldiv_operand_1  : rs - multiplicand / dividend / MTHI-MTLO source
//   i_b_muldiv_operand_2  : rt - multiplier / divisor
//   i_b_muldiv_flush      : abort in-flight operation, blocks a new start
//   o_b_muldiv_busy       : multi-cycle operation in flight
//   o_b_muldiv_done       : one-cycle pulse when new HI/LO first visible
//   o_b_muldiv_hi/_lo     : HI / LO registers
// -----------------------------------------------------------------------------
module b_muldiv
   import mips_pkg::*;
(
   input  logic        i_b_muldiv_clk,
   input  logic        i_b_muldiv_rst_n,
   input  logic        i_b_muldiv_start,
   input  logic [2:0]  i_b_muldiv_ctrl,
   input  logic [31:0] i_b_muldiv_operand_1,
   input  logic [31:0] i_b_muldiv_operand_2,
   input  logic        i_b_muldiv_flush,
   output logic        o_b_muldiv_busy,
   output logic        o_b_muldiv_done,
   output logic [31:0] o_b_muldiv_hi,
   output logic [31:0] o_b_muldiv_lo
);

   muldiv_state_e           state_q, state_d;
   logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]             acc_q, acc_d;
   logic [31:0]             opnd_q, opnd_d;
   logic                    is_div_q, is_div_d;
   logic                    neg_res_q, neg_res_d;   // negate product / quotient
   logic                    neg_rem_q, neg_rem_d;   // negate remainder
   logic                    div_zero_q, div_zero_d;
   logic [31:0]             hi_q, hi_d;
   logic [31:0]             lo_q, lo_d;
   logic                    done_q, done_d;

   muldiv_op_e  op;
   logic        op_signed;
   logic        op_div;
   logic [63:0] step_acc;
   logic        cnt_last;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign op        = muldiv_op_e'(i_b_muldiv_ctrl);
   assign op_signed = ~i_b_muldiv_ctrl[0];
   assign op_div    = i_b_muldiv_ctrl[1];
   assign cnt_last  = (cnt_q == MULDIV_CNT_W'(MULDIV_ITER - 1));

   b_muldiv_step u_step (
      .i_op_div (is_div_q),
      .i_acc    (acc_q),
      .i_opnd   (opnd_q),
      .o_acc    (step_acc)
   );

   // Sign correction applied in FIX. Divide-by-zero needs no special remainder
   // handling: the magnitude datapath leaves |dividend| in the remainder and
   // re-applying the dividend sign restores the value as supplied.
   assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
   assign quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_b_muldiv_start && !i_b_muldiv_flush) begin
               unique case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     acc_d      = {32'd0, abs32(i_b_muldiv_operand_1, op_signed)};
                     opnd_d     = abs32(i_b_muldiv_operand_2, op_signed);
                     is_div_d   = op_div;
                     neg_res_d  = op_signed & (i_b_muldiv_operand_1[31] ^ i_b_muldiv_operand_2[31]);
                     neg_rem_d  = op_signed & i_b_muldiv_operand_1[31];
                     div_zero_d = op_div & (i_b_muldiv_operand_2 == 32'd0);
                     cnt_d      = '0;
                     state_d    = ST_RUN;
                  end
                  OP_MTHI: hi_d = i_b_muldiv_operand_1;
                  OP_MTLO: lo_d = i_b_muldiv_operand_1;
                  default: ;
               endcase
            end
         end

         ST_RUN: begin
            if (i_b_muldiv_flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
               if (cnt_last) begin
                  state_d = ST_FIX;
               end
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            if (!i_b_muldiv_flush) begin
               if (is_div_q) begin
                  lo_d = div_zero_q ? 32'hFFFF_FFFF : quo_fix;
                  hi_d = rem_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
               done_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset along with the control state;
   // they are few and a defined value keeps simulation X-free after reset.
   always_ff @(posedge i_b_muldiv_clk or negedge i_b_muldiv_rst_n) begin
      if (!i_b_muldiv_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign o_b_muldiv_busy = (state_q != ST_IDLE);
   assign o_b_muldiv_done = done_q;
   assign o_b_muldiv_hi   = hi_q;
   assign o_b_muldiv_lo   = lo_q;

endmodule

// File: doc/b_muldiv.md
# b_muldiv

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It sits in EX beside `b_alu` and takes the same operand pair from the ID/EX forwarding muxes. It executes MULT, MULTU, DIV and DIVU over multiple cycles, and MTHI/MTLO in a single cycle. HI/LO are exposed for MFHI/MFLO, and a busy/done handshake lets the hazard unit stall dependent instructions.

## Interface
Parameters:
- none; width is fixed at 32.

Ports:
- `i_b_muldiv_clk`  in  1  single clock; all state updates on the rising edge.
- `i_b_muldiv_rst_n`  in  1  asynchronous, active-low reset.
- `i_b_muldiv_start`  in  1  one-cycle request; sampled only while idle.
- `i_b_muldiv_ctrl`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `i_b_muldiv_operand_1`  in  32  rs value; multiplicand or dividend; MTHI/MTLO source.
- `i_b_muldiv_operand_2`  in  32  rt value; multiplier or divisor.
- `i_b_muldiv_flush`  in  1  abort any in-flight operation.
- `o_b_muldiv_busy`  out  1  high while a multi-cycle operation is in flight.
- `o_b_muldiv_done`  out  1  one-cycle pulse in the cycle the new HI/LO are first visible.
- `o_b_muldiv_hi`  out  32  HI register.
- `o_b_muldiv_lo`  out  32  LO register.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - RUN: 32 radix-2 iterations.
  - FIX: sign correction and HI/LO write-back.
- IDLE with start and ctrl MULT/MULTU/DIV/DIVU:
  - Latch magnitudes of both operands. Signed ops take two's-complement absolute values; unsigned ops take operands as-is.
  - Latch the result-sign flags.
  - Clear the 5-bit iteration counter and go to RUN.
- IDLE with start and MTHI/MTLO:
  - HI (or LO) <= operand_1 on that edge.
  - No busy, no done.
- Start with ctrl 11x: ignored.
- Start while busy: ignored. The hazard unit must hold the instruction in ID while busy is high.
- RUN, multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- RUN exits to FIX when the counter wraps from 31 to 0.
- FIX, signed multiply: negate the 64-bit product if the operand signs differed.
- FIX, signed divide:
  - Negate the quotient if the signs differed.
  - The remainder takes the sign of the dividend.
- FIX write-back: {HI,LO} <= product for multiplies; LO <= quotient and HI <= remainder for divides. Then go to IDLE and pulse done.
- Divide by zero (no trap, full latency): LO = 0xFFFFFFFF, HI = dividend as supplied, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; falls out of the magnitude datapath.
- Flush in RUN or FIX: return to IDLE next edge; HI/LO unchanged; no done. Flush has priority over start and over FIX write-back.
- Reset (asynchronous, any time): state IDLE, counter 0, busy 0, done 0, HI 0, LO 0.

## Timing
- Start sampled at edge E0.
- Busy is high from after E0 through edge E33; it is low again after E33.
- Iterations occur on edges E1..E32; FIX executes on E33.
- HI/LO update and done = 1 occur in the cycle following E33.
- Result latency is 33 cycles from the start edge.
- Back-to-back: a new start may be presented in the done cycle.
- MTHI/MTLO take effect on the start edge.
- HI/LO outputs are registered and have no combinational path from the inputs.

## Structure
- Shared package `mips_pkg`:
  - enum `muldiv_op_e` for the ctrl encodings.
  - enum `muldiv_state_e` for IDLE/RUN/FIX.
  - constant `MULDIV_ITER = 32`.
- One sub-module `b_muldiv_step`: combinational single-iteration datapath (shift-add or trial-subtract, selected by an op flag).
- FSM, counter and HI/LO registers live in the top module.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. The same operands with MULTU -> HI = 0x00000001, LO = 0xFFFFFFFE. Done 33 cycles after start in both cases.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. The same operands with DIVU -> LO = 0x7FFFFFFC, HI = 0x00000001.
- DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> each register updates on its start edge. Busy and done stay 0.
- Preload HI/LO = 0x11/0x22, then start MULT. Flush at cycle 10 -> busy low next cycle, HI/LO remain 0x11/0x22, no done. A second start while busy -> ignored.
- Drop reset at cycle 20 of a DIV -> all outputs 0 immediately. After release, a new MULTU 3 × 5 -> LO = 15, HI = 0.
